// File: rtl/mux_arb_n_pkg.sv
// mux_arb_pkg: shared constants and helpers for the mux_arb_n channel selector.
//   MODE_FIXED / MODE_RR : values of the mode input
//   inc_mod()            : modulo-N increment used for round-robin index arithmetic
package mux_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // (idx + 1) mod n, for idx in [0, n-1].
    function automatic int unsigned inc_mod(input int unsigned idx, input int unsigned n);
        int unsigned nxt;
        nxt = idx + 1;
        if (nxt >= n) begin
            nxt = 0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mux_arb_n_if.sv
// mux_arb_n_if: bundles the selection controls, the N-channel input handshake and the
// registered output handshake of mux_arb_n.
//   mode, select        : selection mode and fixed-mode channel index
//   in_data/in_valid    : packed channel data (channel k at [k*W +: W]) and per-channel valid
//   in_ready            : per-channel ready back to the sources
//   out_data/out_src    : registered selected word and the channel that produced it
//   out_valid/out_ready : output register handshake
// Modports: master drives sources/consumer side (testbench or surrounding logic),
// slave is the selector itself.
interface mux_arb_n_if #(
    parameter int unsigned W = 8,
    parameter int unsigned N = 8
);
    localparam int unsigned S = $clog2(N);

    logic           mode;
    logic [S-1:0]   select;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [S-1:0]   out_src;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output mode, select, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );

    modport slave (
        input  mode, select, in_data, in_valid, out_ready,
        output in_ready, out_data, out_src, out_valid
    );

endinterface

// File: rtl/mux_arb_n_rr_pick.sv
// rr_pick: combinational rotating-priority picker.
//   req     : request vector, one bit per channel
//   ptr     : highest-priority index; scan order is ptr, ptr+1, ... modulo N
//   gnt_idx : index of the first requesting channel in scan order (0 when none)
//   gnt_any : at least one request present
module rr_pick #(
    parameter int unsigned N = 8,
    localparam int unsigned S = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [S-1:0] ptr,
    output logic [S-1:0] gnt_idx,
    output logic         gnt_any
);

    always_comb begin
        int unsigned idx;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            // ptr is always < N, so a single subtraction folds the wrap.
            idx = 32'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = S'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-input, W-bit registered channel selector with valid/ready handshake.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : mux_arb_n_if.slave -- mode/select controls, N input channels with
//           valid/ready, and a one-entry output register with valid/ready.
// mode=0 grants the select channel; mode=1 grants the first valid channel scanning from
// rr_ptr. A one-entry output register accepts a new word whenever it is empty or being
// drained in the same cycle, giving 1 word/cycle throughput.
module mux_arb_n
    import mux_arb_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned N = 8,
    localparam int unsigned S = $clog2(N)
) (
    input logic        clk,
    input logic        reset,
    mux_arb_n_if.slave bus
);

    logic [W-1:0] out_data_q,  out_data_d;
    logic [S-1:0] out_src_q,   out_src_d;
    logic         out_valid_q, out_valid_d;
    logic [S-1:0] rr_ptr_q,    rr_ptr_d;

    logic         accept;
    logic [S-1:0] rr_idx;
    logic         rr_any;
    logic [S-1:0] grant_idx;
    logic         grant_any;
    logic [N-1:0] in_ready_c;
    logic         transfer;
    logic [W-1:0] grant_data;

    rr_pick #(
        .N(N)
    ) u_rr_pick (
        .req     (bus.in_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    assign accept = !out_valid_q || bus.out_ready;

    // Grant selection and ready fan-out. Fixed mode asserts ready on the selected
    // channel regardless of its valid; an out-of-range select grants nothing.
    always_comb begin
        grant_idx  = '0;
        grant_any  = 1'b0;
        in_ready_c = '0;
        if (bus.mode == MODE_RR) begin
            grant_idx = rr_idx;
            grant_any = rr_any;
        end else begin
            grant_idx = bus.select;
            grant_any = (32'(bus.select) < N);
        end
        if (grant_any) begin
            in_ready_c[grant_idx] = accept;
        end
    end

    assign transfer   = grant_any && accept && bus.in_valid[grant_idx];
    assign grant_data = bus.in_data[32'(grant_idx) * W +: W];

    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (transfer) begin
            out_data_d  = grant_data;
            out_src_d   = grant_idx;
            out_valid_d = 1'b1;
            if (bus.mode == MODE_RR) begin
                rr_ptr_d = S'(inc_mod(32'(grant_idx), N));
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: an N=8 instance for fixed mode, backpressure,
// round-robin fairness and wrap/skip, and an N=5 instance for out-of-range select
// and non-power-of-two wrap.
module tb_mux_arb_n;

    logic clk;
    logic reset8;
    logic reset5;
    int   checks;
    int   failures;

    mux_arb_n_if #(.W(8), .N(8)) if8 ();
    mux_arb_n_if #(.W(8), .N(5)) if5 ();

    mux_arb_n #(.W(8), .N(8)) dut8 (.clk(clk), .reset(reset8), .bus(if8));
    mux_arb_n #(.W(8), .N(5)) dut5 (.clk(clk), .reset(reset5), .bus(if5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch8(input int k, input logic [7:0] v);
        if8.in_data[k*8 +: 8] = v;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset8 = 1'b1;
        reset5 = 1'b1;
        if8.mode = 1'b0; if8.select = '0; if8.in_valid = '0; if8.in_data = '0;
        if8.out_ready = 1'b0;
        if5.mode = 1'b0; if5.select = '0; if5.in_valid = '0; if5.in_data = '0;
        if5.out_ready = 1'b0;
        step();
        step();
        reset8 = 1'b0;
        #1;

        // Reset state
        check("rst_valid", 32'(if8.out_valid), 32'h0);
        check("rst_data", 32'(if8.out_data), 32'h0);
        check("rst_src", 32'(if8.out_src), 32'h0);
        check("rst_ready_sel0", 32'(if8.in_ready), 32'h01);

        // Fixed mode, select=3
        for (int k = 0; k < 8; k++) set_ch8(k, 8'(8'h10 + k));
        set_ch8(3, 8'hA5);
        if8.select = 3'd3; if8.in_valid = 8'h08; if8.out_ready = 1'b1;
        #1;
        check("fix_ready", 32'(if8.in_ready), 32'h08);
        step();
        check("fix_data", 32'(if8.out_data), 32'hA5);
        check("fix_src", 32'(if8.out_src), 32'd3);
        check("fix_valid", 32'(if8.out_valid), 32'h1);

        // Backpressure: output held while ch3 data changes
        if8.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_ch8(3, 8'(8'h40 + i));
            #1;
            check("bp_ready", 32'(if8.in_ready), 32'h0);
            step();
            check("bp_data", 32'(if8.out_data), 32'hA5);
            check("bp_valid", 32'(if8.out_valid), 32'h1);
        end
        set_ch8(3, 8'h77);
        if8.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(if8.in_ready), 32'h08);
        step();
        check("bp_release_data", 32'(if8.out_data), 32'h77);
        check("bp_release_valid", 32'(if8.out_valid), 32'h1);

        // Drain with nothing valid: valid drops, data holds
        if8.in_valid = 8'h00;
        step();
        check("drain_valid", 32'(if8.out_valid), 32'h0);
        check("drain_data", 32'(if8.out_data), 32'h77);

        // Round-robin fairness: rr_ptr still 0 since fixed mode never moves it
        set_ch8(3, 8'h13);
        if8.mode = 1'b1; if8.in_valid = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            step();
            check("rr_src", 32'(if8.out_src), 32'(i % 8));
            check("rr_data", 32'(if8.out_data), 32'(8'h10 + (i % 8)));
        end
        // Grants 2..5 move rr_ptr to 6
        for (int i = 2; i < 6; i++) begin
            step();
            check("rr_adv_src", 32'(if8.out_src), 32'(i));
        end

        // Wrap and skip from rr_ptr=6 with in_valid=05: grants 0, 2, 0
        if8.in_valid = 8'h05;
        #1;
        check("wrap_ready0", 32'(if8.in_ready), 32'h01);
        step();
        check("wrap_src0", 32'(if8.out_src), 32'd0);
        #1;
        check("wrap_ready1", 32'(if8.in_ready), 32'h04);
        step();
        check("wrap_src1", 32'(if8.out_src), 32'd2);
        #1;
        check("wrap_ready2", 32'(if8.in_ready), 32'h01);
        step();
        check("wrap_src2", 32'(if8.out_src), 32'd0);
        check("wrap_data2", 32'(if8.out_data), 32'h10);

        // No valid in round-robin: no ready
        if8.in_valid = 8'h00;
        #1;
        check("rr_none_ready", 32'(if8.in_ready), 32'h0);
        step();

        // Load once more (rr_ptr=1 -> grant 1), then stall and change mode: output holds
        if8.in_valid = 8'hFF; if8.out_ready = 1'b1;
        step();
        check("hold_src", 32'(if8.out_src), 32'd1);
        if8.out_ready = 1'b0; if8.mode = 1'b0; if8.select = 3'd6;
        step();
        check("hold_mode_src", 32'(if8.out_src), 32'd1);
        check("hold_mode_data", 32'(if8.out_data), 32'h11);
        check("hold_mode_valid", 32'(if8.out_valid), 32'h1);

        // Reset while out_valid=1 (rr_ptr=2 before reset)
        if8.mode = 1'b1; if8.out_ready = 1'b1;
        reset8 = 1'b1;
        step();
        check("midrst_valid", 32'(if8.out_valid), 32'h0);
        check("midrst_data", 32'(if8.out_data), 32'h0);
        check("midrst_src", 32'(if8.out_src), 32'h0);
        reset8 = 1'b0;
        step();
        check("midrst_ptr_src", 32'(if8.out_src), 32'd0);
        check("midrst_ptr_valid", 32'(if8.out_valid), 32'h1);

        // N=5: out-of-range select grants nothing
        reset5 = 1'b0;
        for (int k = 0; k < 5; k++) if5.in_data[k*8 +: 8] = 8'(8'h50 + k);
        if5.mode = 1'b0; if5.select = 3'd6; if5.in_valid = 5'h1F; if5.out_ready = 1'b1;
        #1;
        check("n5_oor_ready", 32'(if5.in_ready), 32'h0);
        step();
        check("n5_oor_valid0", 32'(if5.out_valid), 32'h0);
        step();
        check("n5_oor_valid1", 32'(if5.out_valid), 32'h0);

        // N=5: top channel in fixed mode
        if5.select = 3'd4;
        #1;
        check("n5_sel4_ready", 32'(if5.in_ready), 32'h10);
        step();
        check("n5_sel4_src", 32'(if5.out_src), 32'd4);
        check("n5_sel4_data", 32'(if5.out_data), 32'h54);

        // N=5: round-robin wraps modulo 5
        if5.mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("n5_rr_src", 32'(if5.out_src), 32'(i % 5));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_arb_n.md
# mux_arb_n

Parametrised N-input, W-bit registered channel selector: the successor to the fixed 8:1 combinational datapath mux. It adds a valid/ready handshake, a one-entry output register and two selection modes: fixed (select-driven) and round-robin arbitration. It sits between multi-cycle CPU datapath sources (register file read ports, ALU result, memory data, immediates) and a shared consumer such as the bus or writeback stage, where a source may not be ready every cycle.

## Interface
Parameters:
- W, 8, data width per channel (≥1)
- N, 8, channel count (≥2; need not be a power of two)
- S, $clog2(N), select/source-index width (derived; do not override)

Ports:
- clk  input  1  rising-edge clock, sole clock
- reset  input  1  synchronous, active-high reset
- mode  input  1  0 = fixed select, 1 = round-robin
- select  input  S  channel index used when mode=0
- in_data  input  N*W  packed channel data; channel k at [k*W +: W]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready (combinational)
- out_data  output  W  registered selected data
- out_src  output  S  registered index of the channel that produced out_data
- out_valid  output  1  output register holds data
- out_ready  input  1  consumer accepts out_data

## Operation
- accept = !out_valid || out_ready. The output register can load this cycle.
- Fixed mode (mode=0):
  - grant = select.
  - in_ready[select] = accept; all other in_ready bits = 0.
  - select ≥ N: no grant, all in_ready = 0, nothing loads.
- Round-robin mode (mode=1):
  - grant = first k with in_valid[k]=1, scanning rr_ptr, rr_ptr+1, … modulo N.
  - in_ready[grant] = accept; all others = 0.
  - No valid channel: in_ready = 0.
- Transfer on channel k when in_valid[k] && in_ready[k]. Registers load:
  - out_data ← channel k data
  - out_src ← k
  - out_valid ← 1
- rr_ptr update: on a transfer in mode 1, rr_ptr ← (k+1) mod N. Otherwise rr_ptr holds. Fixed mode never changes rr_ptr.
- Output handshake: out_valid && out_ready with no new transfer clears out_valid. out_data and out_src hold their last values.
- Simultaneous consume and load: out_valid stays 1 and the new data replaces the old in the same edge. This gives full throughput of 1 word/cycle.
- Stability: while out_valid=1 && out_ready=0, out_data and out_src are held unchanged.
- Upstream rule: sources must not make in_valid depend on in_ready.
- A mode or select change takes effect on the next grant only. It never alters a held output.

## Timing
- Reset values (synchronous, on clk edge with reset=1): out_valid=0, out_data=0, out_src=0, rr_ptr=0. in_ready is combinational and reads 1 only for the fixed-mode select channel, since accept=1 after reset.
- reset wins over any simultaneous transfer. Data in flight is discarded. The cycle after reset deasserts behaves as the first post-reset cycle.
- Latency: input transfer at edge t → out_valid/out_data visible after edge t, i.e. 1 cycle.
- Combinational paths:
  - in_valid → in_ready: round-robin grant only.
  - out_ready → in_ready: via accept.
  - No combinational path from any input to out_data, out_valid or out_src.
- Wrap: with rr_ptr=N-1, the scan covers N-1, 0, 1, …; a grant to N-1 sets rr_ptr=0.

## Structure
- Package mux_arb_pkg holds:
  - MODE_FIXED=1'b0, MODE_RR=1'b1
  - a helper function for the rotate-index arithmetic (mod-N increment)
- Sub-module rr_pick #(N): combinational rotating priority picker.
  - Inputs: req[N-1:0], ptr[S-1:0].
  - Outputs: gnt_idx[S-1:0], gnt_any.
  - Instantiated once inside mux_arb_n.
- Top level holds the accept logic, the grant mux, the output register and rr_ptr.

## Test plan
- Reset / fixed mode (N=8, W=8): reset, then mode=0, select=3, in_valid=8'h08, ch3=8'hA5, out_ready=1. Required: in_ready=8'h08, and next cycle out_data=A5, out_src=3, out_valid=1.
- Backpressure: hold out_ready=0 with out_valid=1 for 4 cycles while ch3 data changes. Required: out_data stays A5, in_ready=0. Then out_ready=1: the new word loads on the same edge and out_valid stays 1.
- Round-robin fairness: mode=1, in_valid=8'hFF every cycle, out_ready=1 for 10 cycles. Required: out_src sequence 0,1,…,7,0,1.
- Wrap and skip: mode=1, rr_ptr=6, in_valid=8'h05. Required: first grant is 0, then 2, then 0.
- Out-of-range and reset mid-operation:
  - N=5, mode=0, select=6, in_valid=all ones. Required: in_ready=0, out_valid stays 0.
  - Assert reset while out_valid=1. Required: out_valid=0, out_data=0, rr_ptr=0 the next cycle.
